pad_io_turnaround: RTL

- Core-side controller for one bidirectional FPGA pad. Drives the pad buffer's OEN/I pins and receives its O pin.
- Serialises DATA_W-bit words onto the pad (TX) and deserialises words from the pad (RX), half-duplex.
- Enforces turnaround gaps so core and external device never drive the pad at the same time.
- Sits between a protocol engine (valid/ready word interface) and a pad_functional-style instance.

---
 rtl/pad_io_turnaround_if.sv | 22 ++
 rtl/pad_io_turnaround.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pad_io_turnaround_if.sv
// Word-level handshake bundle between protocol engine and pad_io_turnaround.
// master = protocol engine, slave = pad controller.
interface pad_io_turnaround_if #(
  parameter int DATA_W = 8
);
  logic              tx_valid_i;
  logic [DATA_W-1:0] tx_data_i;
  logic              tx_ready_o;
  logic              rx_en_i;
  logic              rx_valid_o;
  logic [DATA_W-1:0] rx_data_o;

  modport master (
    output tx_valid_i, tx_data_i, rx_en_i,
    input  tx_ready_o, rx_valid_o, rx_data_o
  );

  modport slave (
    input  tx_valid_i, tx_data_i, rx_en_i,
    output tx_ready_o, rx_valid_o, rx_data_o
  );
endinterface

// File: rtl/pad_io_turnaround.sv
// Half-duplex serial controller for one bidirectional pad with turnaround gaps.
// Optional TX loopback echo check enabled by `define PAD_IO_LOOPBACK_CHECK_EN.
module pad_io_turnaround #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TURN_CYCLES = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  pad_io_turnaround_if.slave bus,
  output logic               pad_oen_o,
  output logic               pad_out_o,
  input  logic               pad_in_i,
  output logic               busy_o,
  output logic               err_o
);

  localparam int TRX_LEN = TURN_CYCLES + SYNC_STAGES;
  localparam int CNT_MAX = (DATA_W > TRX_LEN) ? DATA_W : TRX_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RX_W    = $clog2(DATA_W + 1);
  localparam int TT_L    = (TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0;

  localparam logic [CNT_W-1:0] TT_LAST = CNT_W'(TT_L);
  localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] TR_LAST = CNT_W'(TRX_LEN - 1);
  localparam logic [RX_W-1:0]  RX_LAST = RX_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    RX, TURN_TX, TX, TURN_RX
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [RX_W-1:0]    rx_cnt;
  logic [DATA_W-1:0]  tx_shreg;
  logic [DATA_W-1:0]  rx_shreg;
  logic [DATA_W-1:0]  rx_data;
  logic               rx_valid;
  logic [SYNC_STAGES-1:0] sync;
  logic               pad_sync;
  logic               tx_ready;
  logic               hs;

  // pad_in_i is asynchronous; this chain is its only sampling point
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pad_in_i};
    end
  end

  assign pad_sync = sync[SYNC_STAGES-1];
  assign tx_ready = (state == RX) && (rx_cnt == '0);
  assign hs       = tx_ready && bus.tx_valid_i;

  assign bus.tx_ready_o = tx_ready;
  assign bus.rx_valid_o = rx_valid;
  assign bus.rx_data_o  = rx_data;
  assign busy_o         = (state != RX);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= RX;
      cnt       <= '0;
      rx_cnt    <= '0;
      tx_shreg  <= '0;
      rx_shreg  <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      pad_oen_o <= 1'b1;
      pad_out_o <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      unique case (state)
        RX: begin
          if (hs) begin
            cnt <= '0;
            if (TURN_CYCLES == 0) begin
              state     <= TX;
              pad_oen_o <= 1'b0;
              pad_out_o <= bus.tx_data_i[0];
              tx_shreg  <= bus.tx_data_i >> 1;
            end else begin
              state    <= TURN_TX;
              tx_shreg <= bus.tx_data_i;
            end
          end else if (bus.rx_en_i) begin
            rx_shreg <= {pad_sync, rx_shreg[DATA_W-1:1]};
            if (rx_cnt == RX_LAST) begin
              rx_data  <= {pad_sync, rx_shreg[DATA_W-1:1]};
              rx_valid <= 1'b1;
              rx_cnt   <= '0;
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end else begin
            rx_cnt <= '0;
          end
        end
        TURN_TX: begin
          if (cnt == TT_LAST) begin
            state     <= TX;
            cnt       <= '0;
            pad_oen_o <= 1'b0;
            pad_out_o <= tx_shreg[0];
            tx_shreg  <= tx_shreg >> 1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TX: begin
          if (cnt == TX_LAST) begin
            state     <= TURN_RX;
            cnt       <= '0;
            pad_oen_o <= 1'b1;
            pad_out_o <= 1'b0;
          end else begin
            cnt       <= cnt + 1'b1;
            pad_out_o <= tx_shreg[0];
            tx_shreg  <= tx_shreg >> 1;
          end
        end
        TURN_RX: begin
          if (cnt == TR_LAST) begin
            state  <= RX;
            cnt    <= '0;
            rx_cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef PAD_IO_LOOPBACK_CHECK_EN
  localparam logic [CNT_W-1:0] CHK_FIRST = CNT_W'(SYNC_STAGES);

  logic [SYNC_STAGES-1:0] echo_dly;
  logic                   err_q;

  // echo_dly lines the driven bit up with its return through the synchroniser
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      echo_dly <= '0;
      err_q    <= 1'b0;
    end else begin
      echo_dly <= {echo_dly[SYNC_STAGES-2:0], pad_out_o};
      if (hs) begin
        err_q <= 1'b0;
      end else if ((state == TX) && (cnt >= CHK_FIRST) &&
                   (pad_sync != echo_dly[SYNC_STAGES-1])) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
